// File: rtl/data_memory_responder_pkg.sv
// Shared encodings, request record and byte-lane helpers for the load/store responder.
package data_memory_responder_pkg;

    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic        is_write;
        logic [2:0]  len;
        logic [31:0] wdata;
        logic        err;
    } req_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] len, input logic [1:0] lane);
        logic [3:0] m;
        case (len)
            MEM_LB:  m = 4'b0001 << lane;
            MEM_LH:  m = lane[1] ? 4'b1100 : 4'b0011;
            MEM_LW:  m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] len, input logic [31:0] wd);
        logic [31:0] d;
        case (len)
            MEM_LB:  d = {4{wd[7:0]}};
            MEM_LH:  d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] len, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (len)
            MEM_LB:  r = {{24{b[7]}}, b};
            MEM_LBU: r = {24'd0, b};
            MEM_LH:  r = {{16{h[15]}}, h};
            MEM_LHU: r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_memory_responder_byte_lane_ram.sv
// Four independent 8-bit lanes of DEPTH_WORDS entries: per-lane write enable, registered read.
module byte_lane_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clock,
    input  logic [3:0]    we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rdata_q;

        always_ff @(posedge clock) begin
            if (we_i[g]) mem[addr_i] <= wdata_i[8*g +: 8];
            if (re_i)    rdata_q     <= mem[addr_i];
        end

        assign rdata_o[8*g +: 8] = rdata_q;
    end

endmodule

// File: rtl/data_memory_responder.sv
// Load/store responder: request FSM with wait states, alignment checks and load extension
// in front of a byte-lane RAM.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_op_length,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        resp_valid,
    output logic [31:0] read_data,
    output logic        resp_error
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    req_t          req_q, req_in, acc_req;
    logic [AW+1:0] addr_q, acc_addr;
    logic [31:0]   rdata_hold_q;
    logic          err_hold_q;
    logic          accept, access;
    logic          bad_len, misaligned, oob, bad_store;
    logic [3:0]    ram_we;
    logic          ram_re;
    logic [31:0]   ram_rdata, resp_data;

    always_comb begin
        bad_len    = mem_op_length inside {3'b011, 3'b110, 3'b111};
        misaligned = ((mem_op_length == MEM_LH || mem_op_length == MEM_LHU) && address[0]) ||
                     (mem_op_length == MEM_LW && address[1:0] != 2'b00);
        oob        = {1'b0, address} >= LIMIT;
        bad_store  = mem_write && (mem_op_length == MEM_LBU || mem_op_length == MEM_LHU);
        req_in.is_write = mem_write;
        req_in.len      = mem_op_length;
        req_in.wdata    = write_data;
        req_in.err      = bad_len | misaligned | oob | bad_store | (mem_read & mem_write);
    end

    // read-and-write requests are accepted too so they can be answered with an error
    assign accept = (state_q == ST_IDLE) && req_valid && (mem_read || mem_write);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        access     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait states the access edge is the acceptance edge, before req_q is loaded.
    assign acc_req  = (state_q == ST_IDLE) ? req_in : req_q;
    assign acc_addr = (state_q == ST_IDLE) ? address[AW+1:0] : addr_q;

    assign ram_we = (access && !reset && acc_req.is_write && !acc_req.err)
                  ? lane_mask(acc_req.len, acc_addr[1:0]) : 4'b0000;
    assign ram_re = access && !acc_req.is_write;

    byte_lane_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clock  (clock),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .addr_i (acc_addr[AW+1:2]),
        .wdata_i(store_lanes(acc_req.len, acc_req.wdata)),
        .rdata_o(ram_rdata)
    );

    assign resp_data = (req_q.err || req_q.is_write) ? 32'd0
                     : load_extend(req_q.len, addr_q[1:0], ram_rdata);

    assign read_data  = (state_q == ST_RESP) ? resp_data : rdata_hold_q;
    assign resp_error = (state_q == ST_RESP) ? req_q.err : err_hold_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            req_q        <= '0;
            addr_q       <= '0;
            rdata_hold_q <= 32'd0;
            err_hold_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_q  <= req_in;
                addr_q <= address[AW+1:0];
            end
            if (state_q == ST_RESP) begin
                rdata_hold_q <= resp_data;
                err_hold_q   <= req_q.err;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed checks of the load/store responder: two instances, 2 and 0 wait states.
module tb_data_memory_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, mem_read, mem_write, resp_valid, resp_error;
    logic [2:0]  mem_op_length;
    logic [31:0] address, write_data, read_data;

    logic        r0_valid, r0_ready, r0_read, r0_write, r0_resp, r0_err;
    logic [2:0]  r0_len;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_op_length(mem_op_length),
        .address(address), .write_data(write_data), .resp_valid(resp_valid),
        .read_data(read_data), .resp_error(resp_error)
    );

    data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .req_valid(r0_valid), .req_ready(r0_ready),
        .mem_read(r0_read), .mem_write(r0_write), .mem_op_length(r0_len),
        .address(r0_addr), .write_data(r0_wdata), .resp_valid(r0_resp),
        .read_data(r0_rdata), .resp_error(r0_err)
    );

    // Issues one request on dut from IDLE and waits (bounded) for the response pulse.
    task automatic do_req(input logic rd, input logic wr, input logic [2:0] len,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rdat, output logic err, output int lat);
        req_valid = 1'b1; mem_read = rd; mem_write = wr;
        mem_op_length = len; address = a; write_data = wd;
        @(posedge clock); #1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        lat = 99; rdat = 32'hxxxxxxxx; err = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            if (resp_valid) begin
                lat = k; rdat = read_data; err = resp_error;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", resp_valid); end
        n_checks++; if (read_data !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", read_data); end
        n_checks++; if (resp_error !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", resp_error); end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_word;
        logic [31:0] d; logic e; int l;
        do_req(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, e, l);
        n_checks++; if (l !== 3) begin n_fail++; $display("FAIL sw_latency got %0d want 3", l); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL sw_err got %b want 0", e); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL pulse_width got %b want 0", resp_valid); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got %b want 1", req_ready); end
        do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, d, e, l);
        n_checks++; if (l !== 3) begin n_fail++; $display("FAIL lw_latency got %0d want 3", l); end
        n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data got %h want deadbeef", d); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL lw_err got %b want 0", e); end
        n_checks++; if (read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rdata_hold got %h want deadbeef", read_data); end
    endtask

    task automatic test_byte;
        logic [31:0] d; logic e; int l;
        do_req(1'b0, 1'b1, 3'b000, 32'h11, 32'h00000012, d, e, l);
        do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, d, e, l);
        n_checks++; if (d !== 32'hDEAD12EF) begin n_fail++; $display("FAIL sb_merge got %h want dead12ef", d); end
        do_req(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, d, e, l);
        n_checks++; if (d !== 32'hFFFFFFDE) begin n_fail++; $display("FAIL lb_sext got %h want ffffffde", d); end
        do_req(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, d, e, l);
        n_checks++; if (d !== 32'h000000DE) begin n_fail++; $display("FAIL lbu_zext got %h want 000000de", d); end
        do_req(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, d, e, l);
        n_checks++; if (d !== 32'hFFFFFFEF) begin n_fail++; $display("FAIL lb_lane0 got %h want ffffffef", d); end
    endtask

    task automatic test_half;
        logic [31:0] d; logic e; int l;
        do_req(1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, d, e, l);
        do_req(1'b0, 1'b1, 3'b001, 32'h22, 32'h00008001, d, e, l);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL sh_err got %b want 0", e); end
        do_req(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, d, e, l);
        n_checks++; if (d !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_sext got %h want ffff8001", d); end
        do_req(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, d, e, l);
        n_checks++; if (d !== 32'h00008001) begin n_fail++; $display("FAIL lhu_zext got %h want 00008001", d); end
        do_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, d, e, l);
        n_checks++; if (d !== 32'h80013344) begin n_fail++; $display("FAIL sh_low_kept got %h want 80013344", d); end
        do_req(1'b1, 1'b0, 3'b101, 32'h20, 32'h0, d, e, l);
        n_checks++; if (d !== 32'h00003344) begin n_fail++; $display("FAIL lhu_low got %h want 00003344", d); end
    endtask

    task automatic test_errors;
        logic [31:0] d; logic e; int l; logic seen;
        do_req(1'b1, 1'b0, 3'b010, 32'h02, 32'h0, d, e, l);
        n_checks++; if (e !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL lw_misalign got e=%b d=%h want e=1 d=0", e, d); end
        do_req(1'b0, 1'b1, 3'b001, 32'h21, 32'hFFFFFFFF, d, e, l);
        n_checks++; if (e !== 1'b1 || l !== 3) begin n_fail++; $display("FAIL sh_misalign got e=%b lat=%0d want e=1 lat=3", e, l); end
        do_req(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, d, e, l);
        n_checks++; if (e !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL lw_oob got e=%b d=%h want e=1 d=0", e, d); end
        do_req(1'b1, 1'b0, 3'b011, 32'h20, 32'h0, d, e, l);
        n_checks++; if (e !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL op011 got e=%b d=%h want e=1 d=0", e, d); end
        do_req(1'b0, 1'b1, 3'b100, 32'h20, 32'h000000AA, d, e, l);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL store_bu got e=%b want 1", e); end
        do_req(1'b1, 1'b1, 3'b010, 32'h20, 32'h0BADF00D, d, e, l);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL rd_and_wr got e=%b want 1", e); end
        do_req(1'b0, 1'b1, 3'b010, 32'h1020, 32'h0BADF00D, d, e, l);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL sw_oob got e=%b want 1", e); end
        do_req(1'b1, 1'b0, 3'b010, 32'hFFC, 32'h0, d, e, l);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL lw_last_word got e=%b want 0", e); end
        do_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, d, e, l);
        n_checks++; if (d !== 32'h80013344 || e !== 1'b0) begin n_fail++; $display("FAIL word_after_errs got %h e=%b want 80013344 e=0", d, e); end
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; address = 32'h20;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            if (resp_valid || !req_ready) seen = 1'b1;
        end
        req_valid = 1'b0;
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL noop_ignored got %b want 0", seen); end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] d; logic e; int l; logic seen;
        do_req(1'b0, 1'b1, 3'b010, 32'h30, 32'hA5A5A5A5, d, e, l);
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
        mem_op_length = 3'b010; address = 32'h30; write_data = 32'h00000055;
        @(posedge clock); #1;
        req_valid = 1'b0; mem_write = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_to_idle got rdy=%b vld=%b want 1 0", req_ready, resp_valid); end
        n_checks++; if (read_data !== 32'd0) begin n_fail++; $display("FAIL reset_clears_rdata got %h want 0", read_data); end
        seen = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            if (resp_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL dropped_resp got %b want 0", seen); end
        do_req(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, d, e, l);
        n_checks++; if (d !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL dropped_store got %h want a5a5a5a5", d); end
    endtask

    task automatic test_back_to_back;
        logic [5:0] vpat, rpat;
        r0_valid = 1'b1; r0_read = 1'b0; r0_write = 1'b1;
        r0_len = 3'b010; r0_addr = 32'h40; r0_wdata = 32'hCAFEF00D;
        vpat = '0; rpat = '0;
        @(posedge clock); #1;
        for (int c = 0; c < 6; c++) begin
            vpat[c] = r0_resp;
            rpat[c] = r0_ready;
            if (c == 0) begin r0_read = 1'b1; r0_write = 1'b0; end
            if (c == 2 || c == 4) begin
                n_checks++;
                if (r0_rdata !== 32'hCAFEF00D || r0_err !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_load%0d got %h e=%b want cafef00d e=0", c, r0_rdata, r0_err);
                end
            end
            if (c == 4) r0_valid = 1'b0;
            @(posedge clock); #1;
        end
        n_checks++; if (vpat !== 6'b010101) begin n_fail++; $display("FAIL b2b_valid got %b want 010101", vpat); end
        n_checks++; if (rpat !== 6'b101010) begin n_fail++; $display("FAIL b2b_ready got %b want 101010", rpat); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_op_length = 3'b010; address = '0; write_data = '0;
        r0_valid = 1'b0; r0_read = 1'b0; r0_write = 1'b0;
        r0_len = 3'b010; r0_addr = '0; r0_wdata = '0;
        test_reset;
        test_word;
        test_byte;
        test_half;
        test_errors;
        test_reset_mid_op;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
